areg_mp: RTL and testbench
==========================

AREG_MP -- requirements
Module: areg_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each register in bits.
REQ-002 SHALL have parameter DEPTH, default 16, register count; power of two, at least 2.
REQ-003 SHALL have parameter NRD, default 2, number of independent read ports.
REQ-004 SHALL derive AW = clog2(DEPTH) as the address width.
REQ-005 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port ra  input  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
REQ-008 SHALL have port rval  output  NRD*WIDTH  read data; port k occupies bits [k*WIDTH +: WIDTH].
REQ-009 SHALL have port w  input  1  write request.
REQ-010 SHALL have port y  input  1  write mode: 1 = replace, 0 = accumulate.
REQ-011 SHALL have port wa  input  AW  write address.
REQ-012 SHALL have port wval  input  WIDTH  write operand.
REQ-013 SHALL have port mask  input  WIDTH  bit-enable; a 1 bit takes the new value, a 0 bit keeps the old value.
REQ-014 SHALL have port clr  input  1  bulk-clear request.
REQ-015 SHALL have port busy  output  1  high while a clear is in progress.

Function
REQ-016 SHALL, when w=1 and busy=0, accept the write and compute:
  - cur = the forwarded value of wa (REQ-019);
  - nval = y ? wval : (cur + wval) mod 2^WIDTH;
  - data = (cur & ~mask) | (nval & mask).
REQ-017 SHALL hold an accepted write as a pending entry (addr, data, valid) for one cycle, then commit it to the file on the next rising edge (write latency 2 edges).
REQ-018 SHALL drive each rval port combinationally: pending data when the pending entry is valid and its address matches, otherwise the file entry; zero cycles of read latency.
REQ-019 SHALL use the same pending-over-file forwarding to form cur, so back-to-back accumulates to one address produce the correct running sum with no stall.
REQ-020 SHALL ignore w while busy=1; no pending entry is created.
REQ-021 SHALL implement a state machine with states IDLE and CLEAR.
  - IDLE -> CLEAR: on clr=1.
  - CLEAR: zeroes entry cnt each cycle, cnt = 0..DEPTH-1.
  - CLEAR -> IDLE: after entry DEPTH-1 is zeroed.
REQ-022 SHALL drive busy=1 for exactly DEPTH cycles starting at the edge that samples clr.
REQ-023 SHALL ignore clr while busy=1.
REQ-024 SHALL, when w and clr are both 1 in IDLE, accept the write first; the pending entry commits on the first CLEAR edge and is zeroed when cnt reaches that address.
REQ-025 SHALL, during CLEAR, return partially cleared contents on reads, with pending forwarding still applied.
REQ-026 SHALL allow all NRD ports to read the same or different addresses in the same cycle without conflict.

Reset
REQ-027 SHALL, on rst=1 and regardless of clk, force all DEPTH entries to 0, pending valid to 0, state to IDLE, cnt to 0 and busy to 0.
REQ-028 SHALL, on reset asserted mid-CLEAR or with a write pending, discard that operation; all rval read 0 while rst=1.

Configuration
REQ-029 SHALL, when macro AREG_MIRROR_EN is defined, also write every committed write with addr < DEPTH/2 to addr + DEPTH/2 with identical data.
REQ-030 SHALL, when AREG_MIRROR_EN is defined, apply forwarding on a match with either the pending address or its mirror address.
REQ-031 SHALL, without AREG_MIRROR_EN, write only the addressed entry and include no mirror logic.

Verification
REQ-032 SHALL cover reset: assert rst mid-run -> every rval reads 0, busy=0.
REQ-033 SHALL cover replace then read: w=1, y=1, wa=3, wval=0x1234, mask=all ones -> rval[3]=0x1234 combinationally on the next cycle via bypass, and from the file one cycle later.
REQ-034 SHALL cover accumulate: three consecutive cycles of y=0, wa=5, wval=1 starting from 0 -> entry 5 = 3; then wval=0xFFFFFFFF -> wraps to 2.
REQ-035 SHALL cover masking: entry 7 = 0xAAAA0000; write y=1, wval=0x0000FFFF, mask=0x0000FF00 -> entry 7 = 0xAAAAFF00.
REQ-036 SHALL cover clear: clr and w (wa=9, wval=5) in the same cycle -> busy high 16 cycles, w ignored during busy, all entries 0 afterwards.
REQ-037 SHALL cover mirroring: with AREG_MIRROR_EN, write wa=2, wval=0x77 -> entries 2 and 10 both read 0x77; without it, entry 10 remains 0.

Source files
------------

// File: rtl/areg_mp.sv
// ---------------------------------------------------------------------------
// areg_mp -- multi-ported accumulating register file
//
// A DEPTH x WIDTH register file with NRD combinational read ports and one
// write port. A write either replaces an entry or adds its operand to the
// entry, and a per-bit mask picks which bits change. An accepted write sits
// in a one-entry pending stage for a cycle and then commits to the file.
// Reads and the accumulate path both forward from the pending stage, so
// back-to-back accumulates to one address never stall.
//
// A bulk clear (clr) walks the whole file one entry per cycle, zeroing
// entries 0..DEPTH-1 while busy is high.
//
// Optional feature (macro AREG_MIRROR_EN): every committed write to the
// lower half of the file is also copied to addr + DEPTH/2, and forwarding
// matches the mirror address as well.
//
// Ports:
//   clk   in   clock; all state updates on the rising edge
//   rst   in   asynchronous active-high reset
//   ra    in   NRD read addresses, port k at [k*AW +: AW]
//   rval  out  NRD read data words, port k at [k*WIDTH +: WIDTH]
//   w     in   write request
//   y     in   write mode: 1 = replace, 0 = accumulate
//   wa    in   write address
//   wval  in   write operand
//   mask  in   bit enable: 1 = take the new bit, 0 = keep the old bit
//   clr   in   bulk-clear request
//   busy  out  high while a bulk clear is in progress
// ---------------------------------------------------------------------------
module areg_mp #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int NRD   = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NRD*AW-1:0]    ra,
    output logic [NRD*WIDTH-1:0] rval,
    input  logic                 w,
    input  logic                 y,
    input  logic [AW-1:0]        wa,
    input  logic [WIDTH-1:0]     wval,
    input  logic [WIDTH-1:0]     mask,
    input  logic                 clr,
    output logic                 busy
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;

    logic             pendValid_q, pendValid_d;
    logic [AW-1:0]    pendAddr_q, pendAddr_d;
    logic [WIDTH-1:0] pendData_q, pendData_d;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic             writeAccept;
    logic [WIDTH-1:0] writeCur;
    logic [WIDTH-1:0] writeNew;
    logic [WIDTH-1:0] writeData;

`ifdef AREG_MIRROR_EN
    localparam logic [AW-1:0] HALF = AW'(DEPTH / 2);
`endif

    // True when the pending entry supplies the value seen at addr. With
    // mirroring, a lower-half pending write is also visible at its mirror.
    function automatic logic pendHit(input logic [AW-1:0] addr,
                                     input logic          valid,
                                     input logic [AW-1:0] pAddr);
        logic hit;
        hit = valid && (addr == pAddr);
`ifdef AREG_MIRROR_EN
        if (valid && !pAddr[AW-1] && (addr == (pAddr | HALF))) begin
            hit = 1'b1;
        end
`endif
        return hit;
    endfunction

    assign busy = (state_q == CLEAR);

    // Read ports: pending data overrides the file so a write is visible the
    // cycle after it is accepted, before it has actually committed.
    always_comb begin
        rval = '0;
        for (int k = 0; k < NRD; k++) begin
            if (pendHit(ra[k*AW +: AW], pendValid_q, pendAddr_q)) begin
                rval[k*WIDTH +: WIDTH] = pendData_q;
            end else begin
                rval[k*WIDTH +: WIDTH] = mem_q[ra[k*AW +: AW]];
            end
        end
    end

    // Write datapath: the current value uses the same forwarding as the read
    // ports, so a chain of accumulates to one address sees its running sum.
    always_comb begin
        writeAccept = w && (state_q == IDLE);
        if (pendHit(wa, pendValid_q, pendAddr_q)) begin
            writeCur = pendData_q;
        end else begin
            writeCur = mem_q[wa];
        end
        writeNew  = y ? wval : (writeCur + wval);
        writeData = (writeCur & ~mask) | (writeNew & mask);
    end

    // Pending stage: holds an accepted write for exactly one cycle.
    always_comb begin
        pendValid_d = writeAccept;
        pendAddr_d  = pendAddr_q;
        pendData_d  = pendData_q;
        if (writeAccept) begin
            pendAddr_d = wa;
            pendData_d = writeData;
        end
    end

    // Clear sequencer: a clr seen in IDLE starts a walk over every entry;
    // the walk ends on the edge that zeroes the last entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // File update: commit the pending entry, then apply the clear. The clear
    // comes last so a write accepted together with clr still ends up zeroed
    // when the walk reaches it, even if that happens on the commit edge.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (pendValid_q) begin
            mem_d[pendAddr_q] = pendData_q;
`ifdef AREG_MIRROR_EN
            if (!pendAddr_q[AW-1]) begin
                mem_d[pendAddr_q | HALF] = pendData_q;
            end
`endif
        end
        if (state_q == CLEAR) begin
            mem_d[cnt_q] = '0;
        end
    end

    // State registers; reset discards any pending write or clear in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pendValid_q <= 1'b0;
            pendAddr_q  <= '0;
            pendData_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pendValid_q <= pendValid_d;
            pendAddr_q  <= pendAddr_d;
            pendData_q  <= pendData_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_areg_mp.sv
// ---------------------------------------------------------------------------
// tb_areg_mp -- scoreboard bench for areg_mp
//
// The stimulus side drives one cycle at a time and pushes the read/busy
// values it expects for that cycle into a queue, taken from an architectural
// model: an array of visible register values where a write shows up the
// cycle after it is accepted and a clear zeroes one entry per cycle. A
// separate monitor on the falling edge pops and compares.
// Honours AREG_MIRROR_EN in the model when the design is built with it.
// ---------------------------------------------------------------------------
module tb_areg_mp;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int NRD   = 2;
    localparam int AW    = 4;
`ifdef AREG_MIRROR_EN
    localparam int HALF  = DEPTH / 2;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NRD*AW-1:0]    ra = '0;
    logic [NRD*WIDTH-1:0] rval;
    logic                 w = 1'b0;
    logic                 y = 1'b0;
    logic [AW-1:0]        wa = '0;
    logic [WIDTH-1:0]     wval = '0;
    logic [WIDTH-1:0]     mask = '0;
    logic                 clr = 1'b0;
    logic                 busy;

    typedef struct {
        string            name;
        int               port;
        logic [WIDTH-1:0] expVal;
    } exp_t;

    exp_t             expQ[$];
    int               compared = 0;
    int               mismatched = 0;

    logic [WIDTH-1:0] refMem [DEPTH];
    int               busyLeft = 0;
    int               clrCnt = 0;

    areg_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NRD(NRD)) dut (
        .clk  (clk),
        .rst  (rst),
        .ra   (ra),
        .rval (rval),
        .w    (w),
        .y    (y),
        .wa   (wa),
        .wval (wval),
        .mask (mask),
        .clr  (clr),
        .busy (busy)
    );

    always #5 clk = ~clk;

    // Port index NRD stands for the busy output.
    task automatic checkOutput(input exp_t e);
        logic [WIDTH-1:0] act;
        if (e.port == NRD) begin
            act = {{(WIDTH-1){1'b0}}, busy};
        end else begin
            act = rval[e.port*WIDTH +: WIDTH];
        end
        compared++;
        if (act !== e.expVal) begin
            mismatched++;
            $display("[TB] FAIL %s port%0d: got %h expected %h at %0t",
                     e.name, e.port, act, e.expVal, $time);
        end
    endtask

    always @(negedge clk) begin
        while (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) refMem[i] = '0;
        busyLeft = 0;
        clrCnt   = 0;
    endtask

    // One rising edge of the architectural model.
    task automatic modelEdge();
        logic [WIDTH-1:0] cur, nval, data;
        if (busyLeft > 0) begin
            refMem[clrCnt] = '0;
            clrCnt++;
            busyLeft--;
        end else begin
            if (w) begin
                cur  = refMem[wa];
                nval = y ? wval : cur + wval;
                data = (cur & ~mask) | (nval & mask);
                refMem[wa] = data;
`ifdef AREG_MIRROR_EN
                if (int'(wa) < HALF) refMem[int'(wa) + HALF] = data;
`endif
            end
            if (clr) begin
                busyLeft = DEPTH;
                clrCnt   = 0;
            end
        end
    endtask

    task automatic pushExpect(input string name);
        exp_t e;
        for (int k = 0; k < NRD; k++) begin
            e.name   = name;
            e.port   = k;
            e.expVal = rst ? '0 : refMem[ra[k*AW +: AW]];
            expQ.push_back(e);
        end
        e.name   = name;
        e.port   = NRD;
        e.expVal = (!rst && busyLeft > 0) ? 1 : 0;
        expQ.push_back(e);
    endtask

    // Called just after a rising edge; drives one full cycle.
    task automatic applyStimulus(input string            name,
                                 input logic             iw,
                                 input logic             iy,
                                 input logic [AW-1:0]    iwa,
                                 input logic [WIDTH-1:0] iwval,
                                 input logic [WIDTH-1:0] imask,
                                 input logic             iclr,
                                 input logic [AW-1:0]    r0,
                                 input logic [AW-1:0]    r1);
        w    = iw;
        y    = iy;
        wa   = iwa;
        wval = iwval;
        mask = imask;
        clr  = iclr;
        ra   = {r1, r0};
        pushExpect(name);
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic readAll(input string name);
        for (int i = 0; i < DEPTH; i += 2) begin
            applyStimulus(name, 1'b0, 1'b0, '0, '0, '0, 1'b0, AW'(i), AW'(i + 1));
        end
    endtask

    // Reset asserted between edges; outputs are checked before the next edge.
    task automatic doReset(input string name);
        w   = 1'b0;
        clr = 1'b0;
        ra  = AW'($urandom_range(0, DEPTH - 1)) | (NRD*AW)'($urandom_range(0, DEPTH - 1) << AW);
        rst = 1'b1;
        modelReset();
        pushExpect(name);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        doReset("rst_init");
        readAll("rst_init_read");

        // Replace, then read via bypass and then from the file.
        applyStimulus("replace", 1'b1, 1'b1, 4'd3, 32'h1234, '1, 1'b0, 4'd3, 4'd3);
        applyStimulus("bypass",  1'b0, 1'b0, '0, '0, '0, 1'b0, 4'd3, 4'd0);
        applyStimulus("fileread", 1'b0, 1'b0, '0, '0, '0, 1'b0, 4'd0, 4'd3);

        // Back-to-back accumulates and wraparound.
        for (int i = 0; i < 3; i++) begin
            applyStimulus("accum", 1'b1, 1'b0, 4'd5, 32'd1, '1, 1'b0, 4'd5, 4'd3);
        end
        applyStimulus("accum3", 1'b1, 1'b0, 4'd5, 32'hFFFF_FFFF, '1, 1'b0, 4'd5, 4'd5);
        applyStimulus("wrap",   1'b0, 1'b0, '0, '0, '0, 1'b0, 4'd5, 4'd5);
        applyStimulus("wrapfile", 1'b0, 1'b0, '0, '0, '0, 1'b0, 4'd5, 4'd3);

        // Bit masking.
        applyStimulus("mask_init", 1'b1, 1'b1, 4'd7, 32'hAAAA_0000, '1, 1'b0, 4'd7, 4'd7);
        applyStimulus("mask", 1'b1, 1'b1, 4'd7, 32'h0000_FFFF, 32'h0000_FF00, 1'b0, 4'd7, 4'd7);
        applyStimulus("mask_rd", 1'b0, 1'b0, '0, '0, '0, 1'b0, 4'd7, 4'd7);
        applyStimulus("mask_rd2", 1'b0, 1'b0, '0, '0, '0, 1'b0, 4'd7, 4'd5);

        // Mirror behaviour (or its absence).
        applyStimulus("mirror", 1'b1, 1'b1, 4'd2, 32'h77, '1, 1'b0, 4'd2, 4'd10);
        applyStimulus("mirror_rd", 1'b0, 1'b0, '0, '0, '0, 1'b0, 4'd2, 4'd10);
        applyStimulus("mirror_rd2", 1'b0, 1'b0, '0, '0, '0, 1'b0, 4'd10, 4'd2);

        // Fill some entries, then clear with a simultaneous write.
        for (int i = 8; i < DEPTH; i++) begin
            applyStimulus("fill", 1'b1, 1'b1, AW'(i), $urandom, '1, 1'b0, AW'(i), 4'd9);
        end
        applyStimulus("clr_w", 1'b1, 1'b1, 4'd9, 32'd5, '1, 1'b1, 4'd9, 4'd0);
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus("clearing", 1'b1, $urandom_range(0, 1), AW'($urandom_range(0, DEPTH - 1)),
                          $urandom, '1, 1'b1, 4'd9, AW'(i));
        end
        readAll("after_clear");

        // Reset in the middle of a clear with a write pending just before.
        applyStimulus("pre_rst_w", 1'b1, 1'b1, 4'd4, 32'hDEAD_BEEF, '1, 1'b1, 4'd4, 4'd12);
        applyStimulus("pre_rst", 1'b0, 1'b0, '0, '0, '0, 1'b0, 4'd4, 4'd15);
        applyStimulus("pre_rst", 1'b0, 1'b0, '0, '0, '0, 1'b0, 4'd4, 4'd1);
        doReset("rst_midclear");
        readAll("after_rst");

        // Reset with a write pending.
        applyStimulus("pend_w", 1'b1, 1'b1, 4'd6, 32'h1357, '1, 1'b0, 4'd6, 4'd6);
        doReset("rst_pending");
        applyStimulus("after_rst_pend", 1'b0, 1'b0, '0, '0, '0, 1'b0, 4'd6, 4'd14);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            applyStimulus("random",
                          $urandom_range(0, 1),
                          $urandom_range(0, 1),
                          AW'($urandom_range(0, DEPTH - 1)),
                          ($urandom_range(0, 1) != 0) ? $urandom : WIDTH'($urandom_range(0, 7)),
                          ($urandom_range(0, 2) != 0) ? '1 : $urandom,
                          ($urandom_range(0, 39) == 0),
                          AW'($urandom_range(0, DEPTH - 1)),
                          AW'($urandom_range(0, DEPTH - 1)));
        end
        readAll("final");

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
